// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state types and baud divisor helper for uart_core_p
package uart_pkg;

    localparam int OVS      = 16;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud * longint'(OVS) / 2) / (baud * longint'(OVS)));
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: count-based circular FIFO with a first-word-fall-through head
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    assign dout    = empty ? '0 : mem[rp];

    // storage write at the tail
    always_ff @(posedge clk100)
        if (do_push) mem[wp] <= din;

    // wrap-around pointers and occupancy count
    always_ff @(posedge clk100) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_core_p.sv
// uart_core_p: parametrised UART with 16x oversampled RX, FIFOs and sticky errors
module uart_core_p
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 19200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 rx,
    output logic                 tx,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 rx_empty,
    output logic                 tx_full,
    input  logic                 err_clr,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam longint CLK_L   = longint'(CLK_HZ);
    localparam longint BAUD_L  = longint'(BAUD);
    localparam int     DIV     = calc_div(CLK_L, BAUD_L);
    localparam longint ACT     = longint'(DIV) * longint'(OVS) * BAUD_L;
    localparam longint ERR     = ACT > CLK_L ? ACT - CLK_L : CLK_L - ACT;
    localparam int     CW      = $clog2(DIV + 1);
    localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
    localparam logic   PAR_EN  = PARITY != PAR_NONE;
    localparam logic   PAR_INV = PARITY == PAR_ODD;

    if (DIV < 1 || ERR * 50 > ACT) begin : g_bad_baud
        $error("uart_core_p: baud rate error exceeds two percent");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        !(PARITY == PAR_NONE || PARITY == PAR_ODD || PARITY == PAR_EVEN)) begin : g_bad_cfg
        $error("uart_core_p: unsupported frame format");
    end

    logic [CW-1:0]        div_cnt;
    logic                 tick;
    logic [1:0]           rx_sync;
    logic                 rxd;
    rx_state_t            rx_state, rx_next;
    logic [3:0]           rx_tc, rx_tc_n, rx_bc, rx_bc_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n, rx_word;
    logic                 rx_pb, rx_pb_n, rx_mid, rx_done;
    logic                 pe_ev, fe_ev, good_ev, rx_push, rx_full;
    tx_state_t            tx_state, tx_next;
    logic [3:0]           tx_tc, tx_tc_n, tx_bc, tx_bc_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n, tx_head;
    logic                 tx_pb, tx_pb_n, tx_mid, tx_pop, tx_empty;

    assign tick = div_cnt == CW'(DIV - 1);
    assign rxd  = rx_sync[1];

    // baud divider producing one 16x oversample tick every DIV cycles
    always_ff @(posedge clk100)
        div_cnt <= (reset || tick) ? '0 : div_cnt + 1'b1;

    // two-flop synchroniser for the asynchronous rx pin; idles high
    always_ff @(posedge clk100)
        rx_sync <= reset ? 2'b11 : {rx_sync[0], rx};

    assign rx_mid  = tick && rx_tc == 4'd15;
    assign fe_ev   = rx_done & ~rxd;
    assign pe_ev   = rx_done & rxd & PAR_EN & (^rx_sh ^ rx_pb ^ PAR_INV);
    assign good_ev = rx_done & rxd & ~pe_ev;

    // RX next state: mid start bit after 8 ticks, then one sample per 16 ticks
    always_comb begin
        rx_next = rx_state;
        rx_tc_n = rx_tc;
        rx_bc_n = rx_bc;
        rx_sh_n = rx_sh;
        rx_pb_n = rx_pb;
        rx_done = 1'b0;
        if (rx_state != RX_IDLE && tick) rx_tc_n = rx_tc + 4'd1;
        case (rx_state)
            RX_IDLE: if (!rxd) begin
                rx_next = RX_START;
                rx_tc_n = '0;
            end
            RX_START: if (tick && rx_tc == 4'd7) begin
                rx_next = rxd ? RX_IDLE : RX_DATA;
                rx_tc_n = '0;
                rx_bc_n = '0;
            end
            RX_DATA: if (rx_mid) begin
                rx_sh_n = {rxd, rx_sh[DATA_BITS-1:1]};
                rx_bc_n = rx_bc + 4'd1;
                if (rx_bc == DLAST) rx_next = PAR_EN ? RX_PAR : RX_STOP;
            end
            RX_PAR: if (rx_mid) begin
                rx_pb_n = rxd;
                rx_next = RX_STOP;
            end
            RX_STOP: if (rx_mid) begin
                rx_done = 1'b1;
                rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX state and datapath registers
    always_ff @(posedge clk100) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_tc    <= '0;
            rx_bc    <= '0;
            rx_sh    <= '0;
            rx_pb    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_tc    <= rx_tc_n;
            rx_bc    <= rx_bc_n;
            rx_sh    <= rx_sh_n;
            rx_pb    <= rx_pb_n;
        end
    end

    // push one cycle after the stop sample; a fresh error event beats err_clr
    always_ff @(posedge clk100) begin
        if (reset) begin
            rx_push    <= 1'b0;
            rx_word    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_push    <= good_ev & ~rx_full;
            rx_word    <= rx_sh;
            parity_err <= pe_ev | (parity_err & ~err_clr);
            frame_err  <= fe_ev | (frame_err & ~err_clr);
            overrun    <= (good_ev & rx_full) | (overrun & ~err_clr);
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk100 (clk100),
        .reset  (reset),
        .push   (rx_push),
        .pop    (rd & ~rx_empty),
        .din    (rx_word),
        .dout   (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk100 (clk100),
        .reset  (reset),
        .push   (wr & ~tx_full),
        .pop    (tx_pop),
        .din    (w_data),
        .dout   (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    assign tx_mid = tick && tx_tc == 4'd15;
    assign tx     = tx_state == TX_START ? 1'b0 :
                    tx_state == TX_DATA  ? tx_sh[0] :
                    tx_state == TX_PAR   ? tx_pb : 1'b1;

    // TX next state: frames start on a tick and chain back-to-back from STOP
    always_comb begin
        tx_next = tx_state;
        tx_tc_n = tx_tc;
        tx_bc_n = tx_bc;
        tx_sh_n = tx_sh;
        tx_pb_n = tx_pb;
        tx_pop  = 1'b0;
        if (tx_state != TX_IDLE && tick) tx_tc_n = tx_tc + 4'd1;
        case (tx_state)
            TX_IDLE: tx_pop = tick & ~tx_empty;
            TX_START: if (tx_mid) begin
                tx_next = TX_DATA;
                tx_bc_n = '0;
            end
            TX_DATA: if (tx_mid) begin
                tx_sh_n = tx_sh >> 1;
                tx_bc_n = tx_bc + 4'd1;
                if (tx_bc == DLAST) begin
                    tx_next = PAR_EN ? TX_PAR : TX_STOP;
                    tx_bc_n = '0;
                end
            end
            TX_PAR: if (tx_mid) tx_next = TX_STOP;
            TX_STOP: if (tx_mid) begin
                tx_bc_n = tx_bc + 4'd1;
                if (tx_bc == SLAST) begin
                    tx_next = TX_IDLE;
                    tx_pop  = ~tx_empty;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_next = TX_START;
            tx_sh_n = tx_head;
            tx_pb_n = ^tx_head ^ PAR_INV;
            tx_tc_n = '0;
        end
    end

    // TX state and shift registers
    always_ff @(posedge clk100) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tc    <= '0;
            tx_bc    <= '0;
            tx_sh    <= '0;
            tx_pb    <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_tc    <= tx_tc_n;
            tx_bc    <= tx_bc_n;
            tx_sh    <= tx_sh_n;
            tx_pb    <= tx_pb_n;
        end
    end

endmodule

// File: tb/tb_uart_core_p.sv
// tb_uart_core_p: directed checks of uart_core_p against a frame-level model
module tb_uart_core_p;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int BIT    = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset8 = 1'b1, rd8 = 1'b0, wr8 = 1'b0, rx8 = 1'b1, err_clr8 = 1'b0;
    logic [7:0] w_data8 = '0, r_data8;
    logic       tx8, rx_empty8, tx_full8, pe8, fe8, ov8;

    logic       reset7 = 1'b1, rd7 = 1'b0, wr7 = 1'b0, rx7 = 1'b1, err_clr7 = 1'b0;
    logic [6:0] w_data7 = '0, r_data7;
    logic       tx7, rx_empty7, tx_full7, pe7, fe7, ov7;

    uart_core_p #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u8n1 (
        .clk100(clk), .reset(reset8), .rd(rd8), .wr(wr8), .w_data(w_data8), .rx(rx8),
        .tx(tx8), .r_data(r_data8), .rx_empty(rx_empty8), .tx_full(tx_full8),
        .err_clr(err_clr8), .parity_err(pe8), .frame_err(fe8), .overrun(ov8)
    );

    uart_core_p #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2)) u7e1 (
        .clk100(clk), .reset(reset7), .rd(rd7), .wr(wr7), .w_data(w_data7), .rx(rx7),
        .tx(tx7), .r_data(r_data7), .rx_empty(rx_empty7), .tx_full(tx_full7),
        .err_clr(err_clr7), .parity_err(pe7), .frame_err(fe7), .overrun(ov7)
    );

    int checks = 0;
    int failures = 0;
    logic [6:0] rq[$];
    bit m_pe = 0, m_fe = 0, m_ov = 0;
    bit live = 0, settled = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] frame8(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // every cycle: idle-side invariants, and the RX model whenever no frame is in flight
    always @(negedge clk) if (live) begin
        chk("rx8_empty", rx_empty8, 1);
        chk("rx8_flags", {pe8, fe8, ov8}, 0);
        chk("tx7_idle", tx7, 1);
        if (settled) begin
            chk("rx_empty", rx_empty7, rq.size() == 0);
            if (rq.size() != 0) chk("r_data", r_data7, rq[0]);
            chk("parity_err", pe7, m_pe);
            chk("frame_err", fe7, m_fe);
            chk("overrun", ov7, m_ov);
        end
    end

    task automatic send7(input logic [6:0] d, input bit pflip, input bit stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, (^d) ^ pflip, d, 1'b0};
        settled = 0;
        for (int i = 0; i < 10; i++) begin
            rx7 = bits[i];
            cyc((i == 9 && !stop_ok) ? 100 : BIT);
        end
        rx7 = 1'b1;
        cyc(260);
        if (!stop_ok) m_fe = 1;
        else if (pflip) m_pe = 1;
        else if (rq.size() == 4) m_ov = 1;
        else rq.push_back(d);
        settled = 1;
    endtask

    task automatic read7();
        rd7 = 1'b1;
        cyc(1);
        rd7 = 1'b0;
        if (rq.size() != 0) void'(rq.pop_front());
    endtask

    task automatic clear7();
        err_clr7 = 1'b1;
        cyc(1);
        err_clr7 = 1'b0;
        m_pe = 0;
        m_fe = 0;
        m_ov = 0;
    endtask

    task automatic check_line(input logic [9:0] f, input int skip);
        cyc(BIT / 2 - skip);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("tx_bit%0d", b), tx8, f[b]);
            if (b < 9) cyc(BIT);
        end
    endtask

    task automatic wait_fall8(input int lim, output int n);
        n = 0;
        while (tx8 !== 1'b0 && n < lim) begin
            cyc(1);
            n++;
        end
        chk("tx_fall_in_time", n < lim, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        cyc(3);
        chk("rst_tx8", tx8, 1);
        chk("rst_tx7", tx7, 1);
        chk("rst_rx_empty8", rx_empty8, 1);
        chk("rst_rx_empty7", rx_empty7, 1);
        chk("rst_tx_full8", tx_full8, 0);
        chk("rst_tx_full7", tx_full7, 0);
        chk("rst_flags7", {pe7, fe7, ov7}, 0);
        chk("rst_r_data7", r_data7, 0);
        chk("rst_r_data8", r_data8, 0);
        reset8 = 1'b0;
        reset7 = 1'b0;
        cyc(5);
        live = 1;
        settled = 1;

        wr8 = 1'b1;
        w_data8 = 8'hA5;
        cyc(1);
        wr8 = 1'b0;
        n = 1;
        while (tx8 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("wr_to_start_le13", n <= 13, 1);
        wr8 = 1'b1;
        w_data8 = 8'h3C;
        cyc(1);
        wr8 = 1'b0;
        check_line(10'b1_1010_0101_0, 1);
        wait_fall8(200, n);
        chk("frame_len", 1520 + n, 1600);
        check_line(frame8(8'h3C), 0);
        cyc(200);
        chk("tx_full_idle", tx_full8, 0);

        send7(7'h55, 0, 1);
        chk("rx_55", r_data7, 7'h55);
        chk("rx_55_nonempty", rx_empty7, 0);
        read7();
        cyc(2);
        send7(7'h55, 1, 1);
        chk("par_err_set", pe7, 1);
        chk("par_err_discard", rx_empty7, 1);
        clear7();
        cyc(2);

        send7(7'h33, 0, 0);
        chk("frame_err_set", fe7, 1);
        chk("frame_err_discard", rx_empty7, 1);
        clear7();
        cyc(1);
        chk("frame_err_clr", fe7, 0);

        for (int k = 1; k <= 5; k++) send7(7'(k), 0, 1);
        chk("overrun_set", ov7, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("rd_head", r_data7, k);
            read7();
            cyc(2);
        end
        chk("drained", rx_empty7, 1);
        clear7();
        cyc(2);

        rx7 = 1'b0;
        cyc(50);
        rx7 = 1'b1;
        cyc(200);
        chk("glitch_no_push", rx_empty7, 1);
        chk("glitch_no_flags", {pe7, fe7, ov7}, 0);
        send7(7'h2A, 0, 1);
        chk("after_glitch", r_data7, 7'h2A);
        read7();
        cyc(2);

        wr8 = 1'b1;
        w_data8 = 8'h5A;
        cyc(1);
        w_data8 = 8'h11;
        cyc(1);
        wr8 = 1'b0;
        wait_fall8(20, n);
        cyc(400);
        reset8 = 1'b1;
        cyc(1);
        reset8 = 1'b0;
        chk("reset_tx_high", tx8, 1);
        chk("reset_tx_full", tx_full8, 0);
        low = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (!tx8) low++;
        end
        chk("no_tx_after_reset", low, 0);

        live = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
